panda_operand_fetch: RTL and testbench

Operand-fetch/issue stage of the Panda pipeline, the consumer side of `panda_register_file`. It accepts decoded instructions over a valid/ready handshake and drives the register file read ports. A 32-entry scoreboard of pending writes detects RAW/WAW hazards and stalls until the write retires. The stage registers the operands, with optional same-cycle writeback bypass, and hands them to execute over a second valid/ready handshake.

---
 rtl/panda_operand_fetch.sv | 76 +++++++
 tb/tb_panda_operand_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_operand_fetch.sv
// panda_operand_fetch: operand fetch/issue stage with a 32-entry pending-write scoreboard.
// Define PANDA_OF_WB_BYPASS_EN to forward same-cycle writeback data and release hazards early.
module panda_operand_fetch (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  logic [4:0]  dec_rs1_addr_i,
    input  logic [4:0]  dec_rs2_addr_i,
    input  logic [4:0]  dec_rd_addr_i,
    input  logic        dec_rd_we_i,
    output logic [4:0]  rf_rs1_addr_o,
    output logic [4:0]  rf_rs2_addr_o,
    input  logic [31:0] rf_rs1_data_i,
    input  logic [31:0] rf_rs2_data_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic [31:0] wb_rd_data_i,
    input  logic        wb_rd_we_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] ex_rs1_data_o,
    output logic [31:0] ex_rs2_data_o,
    output logic [4:0]  ex_rd_addr_o,
    output logic        ex_rd_we_o,
    output logic        busy_o
);
    logic [31:0] pending, pend_eff, clr_mask, set_mask, op1, op2;
    logic        hazard, issue;

    assign rf_rs1_addr_o = dec_rs1_addr_i;
    assign rf_rs2_addr_o = dec_rs2_addr_i;
    assign clr_mask = (wb_rd_we_i && wb_rd_addr_i != 5'd0) ? 32'd1 << wb_rd_addr_i : 32'd0;
    assign set_mask = (issue && dec_rd_we_i && dec_rd_addr_i != 5'd0) ? 32'd1 << dec_rd_addr_i : 32'd0;
`ifdef PANDA_OF_WB_BYPASS_EN
    assign pend_eff = pending & ~clr_mask;
    assign op1 = dec_rs1_addr_i == 5'd0 ? 32'd0 :
                 (wb_rd_we_i && wb_rd_addr_i == dec_rs1_addr_i) ? wb_rd_data_i : rf_rs1_data_i;
    assign op2 = dec_rs2_addr_i == 5'd0 ? 32'd0 :
                 (wb_rd_we_i && wb_rd_addr_i == dec_rs2_addr_i) ? wb_rd_data_i : rf_rs2_data_i;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_rd_data_i;
    assign pend_eff = pending;
    assign op1 = dec_rs1_addr_i == 5'd0 ? 32'd0 : rf_rs1_data_i;
    assign op2 = dec_rs2_addr_i == 5'd0 ? 32'd0 : rf_rs2_data_i;
`endif
    // bit 0 is never set, so x0 reads and writes never hazard
    assign hazard = pend_eff[dec_rs1_addr_i] | pend_eff[dec_rs2_addr_i] |
                    (dec_rd_we_i & pend_eff[dec_rd_addr_i]);
    assign dec_ready_o = (~ex_valid_o | ex_ready_i) & ~hazard;
    assign issue = dec_valid_i & dec_ready_o;
    assign busy_o = |pending;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending       <= 32'd0;
            ex_valid_o    <= 1'b0;
            ex_rs1_data_o <= 32'd0;
            ex_rs2_data_o <= 32'd0;
            ex_rd_addr_o  <= 5'd0;
            ex_rd_we_o    <= 1'b0;
        end else begin
            // set applied after clear: the issuing writer is younger than the retiring one
            pending <= (pending & ~clr_mask) | set_mask;
            if (issue) begin
                ex_valid_o    <= 1'b1;
                ex_rs1_data_o <= op1;
                ex_rs2_data_o <= op2;
                ex_rd_addr_o  <= dec_rd_addr_i;
                ex_rd_we_o    <= dec_rd_we_i;
            end else if (ex_ready_i) begin
                ex_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_panda_operand_fetch.sv
// tb_panda_operand_fetch: directed self-checking bench for panda_operand_fetch.
// Expectations follow PANDA_OF_WB_BYPASS_EN when it is defined for the build.
module tb_panda_operand_fetch;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        dec_valid_i, dec_ready_o, dec_rd_we_i;
    logic [4:0]  dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i;
    logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o, wb_rd_addr_i, ex_rd_addr_o;
    logic [31:0] rf_rs1_data_i, rf_rs2_data_i, wb_rd_data_i, ex_rs1_data_o, ex_rs2_data_o;
    logic        wb_rd_we_i, ex_valid_o, ex_ready_i, ex_rd_we_o, busy_o;
    logic [31:0] rf [32];
    int checks = 0, fails = 0;

    panda_operand_fetch dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i),
        .dec_rd_addr_i(dec_rd_addr_i), .dec_rd_we_i(dec_rd_we_i),
        .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i), .wb_rd_we_i(wb_rd_we_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_we_o(ex_rd_we_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // register file model sharing the writeback port with the DUT
    assign rf_rs1_data_i = rf[rf_rs1_addr_o];
    assign rf_rs2_data_i = rf[rf_rs2_addr_o];
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + i;
        end else if (wb_rd_we_i && wb_rd_addr_i != 5'd0) begin
            rf[wb_rd_addr_i] <= wb_rd_data_i;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        dec_valid_i = 0; dec_rs1_addr_i = 0; dec_rs2_addr_i = 0; dec_rd_addr_i = 0; dec_rd_we_i = 0;
        wb_rd_we_i = 0; wb_rd_addr_i = 0; wb_rd_data_i = 0; ex_ready_i = 1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic we);
        dec_valid_i = 1; dec_rs1_addr_i = rs1; dec_rs2_addr_i = rs2; dec_rd_addr_i = rd; dec_rd_we_i = we;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_rd_we_i = 1; wb_rd_addr_i = a; wb_rd_data_i = d;
    endtask

    task automatic retire(input logic [4:0] a, input logic [31:0] d);
        wb(a, d);
        tick();
        wb_rd_we_i = 0;
    endtask

    // reads the stall decision for a lone rs1 read with decode idle
    task automatic probe(input logic [4:0] r, output logic rdy);
        dec_valid_i = 0; dec_rs1_addr_i = r; dec_rs2_addr_i = 0; dec_rd_addr_i = 0; dec_rd_we_i = 0;
        #1;
        rdy = dec_ready_o;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 0;
        tick(); tick();
        checks++; if (ex_valid_o !== 1'b0) begin fails++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL reset_dec_ready got=%b exp=1", dec_ready_o); end
        checks++; if ({ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_we_o} !== 70'd0) begin
            fails++; $display("FAIL reset_ex_data got=%h/%h/%h/%b exp=0", ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_we_o);
        end
        rst_ni = 1;
        tick();
    endtask

    task automatic test_independent();
        logic rdy;
        idle();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 5'(i), 1);
            #1;
            checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL indep_ready[%0d] got=%b exp=1", i, dec_ready_o); end
            tick();
            checks++; if (ex_valid_o !== 1'b1 || ex_rd_addr_o !== 5'(i) || ex_rd_we_o !== 1'b1) begin
                fails++; $display("FAIL indep_issue[%0d] got valid=%b rd=%0d we=%b exp valid=1 rd=%0d we=1", i, ex_valid_o, ex_rd_addr_o, ex_rd_we_o, i);
            end
        end
        idle();
        tick();
        checks++; if (ex_valid_o !== 1'b0) begin fails++; $display("FAIL indep_drain got=%b exp=0", ex_valid_o); end
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL indep_busy got=%b exp=1", busy_o); end
        for (int r = 1; r <= 5; r++) begin
            probe(5'(r), rdy);
            checks++; if (rdy !== (r > 4)) begin fails++; $display("FAIL indep_pending[%0d] ready got=%b exp=%b", r, rdy, r > 4); end
        end
        idle();
        for (int i = 1; i <= 4; i++) retire(5'(i), 32'h100 + i);
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL indep_cleared busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_raw();
        idle();
        drive(0, 0, 5, 1);
        tick();
        drive(5, 0, 6, 1);
        #1;
        checks++; if (dec_ready_o !== 1'b0) begin fails++; $display("FAIL raw_stall0 got=%b exp=0", dec_ready_o); end
        tick();
        checks++; if (dec_ready_o !== 1'b0 || ex_valid_o !== 1'b0) begin
            fails++; $display("FAIL raw_stall1 got ready=%b valid=%b exp 0/0", dec_ready_o, ex_valid_o);
        end
        wb(5, 32'hDEAD_BEEF);
        #1;
`ifdef PANDA_OF_WB_BYPASS_EN
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL raw_bypass_ready got=%b exp=1", dec_ready_o); end
        tick();
        wb_rd_we_i = 0;
`else
        checks++; if (dec_ready_o !== 1'b0) begin fails++; $display("FAIL raw_wb_cycle_ready got=%b exp=0", dec_ready_o); end
        tick();
        wb_rd_we_i = 0;
        #1;
        checks++; if (dec_ready_o !== 1'b1 || ex_valid_o !== 1'b0) begin
            fails++; $display("FAIL raw_after_wb got ready=%b valid=%b exp 1/0", dec_ready_o, ex_valid_o);
        end
        tick();
`endif
        checks++; if (ex_valid_o !== 1'b1 || ex_rs1_data_o !== 32'hDEAD_BEEF || ex_rd_addr_o !== 5'd6) begin
            fails++; $display("FAIL raw_issue got valid=%b rs1=%h rd=%0d exp 1/deadbeef/6", ex_valid_o, ex_rs1_data_o, ex_rd_addr_o);
        end
        idle();
        retire(6, 32'h66);
    endtask

    task automatic test_waw();
        logic rdy;
        idle();
        drive(0, 0, 7, 1);
        tick();
        drive(0, 0, 7, 1);
        #1;
        checks++; if (dec_ready_o !== 1'b0) begin fails++; $display("FAIL waw_stall got=%b exp=0", dec_ready_o); end
        wb(7, 32'h77);
        #1;
`ifdef PANDA_OF_WB_BYPASS_EN
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL waw_release got=%b exp=1", dec_ready_o); end
        tick();
        wb_rd_we_i = 0;
`else
        checks++; if (dec_ready_o !== 1'b0) begin fails++; $display("FAIL waw_wb_cycle got=%b exp=0", dec_ready_o); end
        tick();
        wb_rd_we_i = 0;
        #1;
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL waw_release got=%b exp=1", dec_ready_o); end
        tick();
`endif
        idle();
        probe(7, rdy);
        checks++; if (rdy !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL waw_pending7 got ready=%b busy=%b exp 0/1", rdy, busy_o); end
        drive(0, 0, 9, 1);
        wb(9, 32'h99);
        #1;
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL setclr_ready got=%b exp=1", dec_ready_o); end
        tick();
        idle();
        probe(9, rdy);
        checks++; if (rdy !== 1'b0) begin fails++; $display("FAIL setclr_pending9 ready got=%b exp=0", rdy); end
        idle();
        retire(7, 32'h70);
        retire(9, 32'h90);
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL waw_cleared busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_x0();
        idle();
        drive(0, 0, 0, 1);
        #1;
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL x0_ready got=%b exp=1", dec_ready_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL x0_no_pending got valid=%b busy=%b exp 1/0", ex_valid_o, busy_o); end
        drive(0, 0, 0, 0);
        wb(0, 32'hFFFF_FFFF);
        #1;
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL x0_read_ready got=%b exp=1", dec_ready_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b1 || ex_rs1_data_o !== 32'd0 || ex_rs2_data_o !== 32'd0) begin
            fails++; $display("FAIL x0_operand got valid=%b rs1=%h rs2=%h exp 1/0/0", ex_valid_o, ex_rs1_data_o, ex_rs2_data_o);
        end
        idle();
        tick();
    endtask

    task automatic test_back_pressure();
        idle();
        ex_ready_i = 0;
        drive(3, 4, 8, 1);
        #1;
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL bp_first_ready got=%b exp=1", dec_ready_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b1 || ex_rs1_data_o !== 32'h103 || ex_rs2_data_o !== 32'h104 || ex_rd_addr_o !== 5'd8) begin
            fails++; $display("FAIL bp_load got valid=%b rs1=%h rs2=%h rd=%0d exp 1/103/104/8", ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o);
        end
        drive(1, 0, 9, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (dec_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d] got=%b exp=0", k, dec_ready_o); end
            checks++; if (ex_valid_o !== 1'b1 || ex_rs1_data_o !== 32'h103 || ex_rs2_data_o !== 32'h104 || ex_rd_addr_o !== 5'd8 || ex_rd_we_o !== 1'b1) begin
                fails++; $display("FAIL bp_hold[%0d] got valid=%b rs1=%h rs2=%h rd=%0d we=%b exp 1/103/104/8/1", k, ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_we_o);
            end
            if (k == 1) wb(8, 32'h88);
            tick();
            wb_rd_we_i = 0;
        end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL bp_wb_clear busy got=%b exp=0", busy_o); end
        ex_ready_i = 1;
        #1;
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL bp_release got=%b exp=1", dec_ready_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b1 || ex_rd_addr_o !== 5'd9 || ex_rs1_data_o !== 32'h101) begin
            fails++; $display("FAIL bp_next got valid=%b rd=%0d rs1=%h exp 1/9/101", ex_valid_o, ex_rd_addr_o, ex_rs1_data_o);
        end
        idle();
        retire(9, 32'h9);
    endtask

    task automatic test_reset_mid();
        idle();
        ex_ready_i = 0;
        drive(3, 0, 5, 1);
        tick();
        idle();
        ex_ready_i = 0;
        checks++; if (ex_valid_o !== 1'b1 || busy_o !== 1'b1) begin fails++; $display("FAIL rstmid_setup got valid=%b busy=%b exp 1/1", ex_valid_o, busy_o); end
        #2;
        rst_ni = 0;
        #1;
        checks++; if (ex_valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL rstmid_clear got valid=%b busy=%b exp 0/0", ex_valid_o, busy_o); end
        checks++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL rstmid_ready got=%b exp=1", dec_ready_o); end
        checks++; if ({ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_we_o} !== 70'd0) begin
            fails++; $display("FAIL rstmid_data got=%h/%h/%h/%b exp=0", ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_we_o);
        end
        tick();
        rst_ni = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_waw();
        test_x0();
        test_back_pressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
